// File: rtl/branch_squash_tracker_pkg.sv
// Shared core types for branch writeback, redirect payloads and ROB age ordering.
// The older() rule treats the ROB index flag as a wrap bit.
package branch_squash_tracker_pkg;

    localparam int ROB_SIZE_P = 64;
    localparam int ROB_IDX_W  = $clog2(ROB_SIZE_P);
    localparam int FTQ_IDX_W  = 4;
    localparam int BROB_IDX_W = 4;
    localparam int VADDR_W    = 39;

    typedef struct packed {
        logic                 flag;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef logic [FTQ_IDX_W-1:0]  ftqIdx_t;
    typedef logic [BROB_IDX_W-1:0] brobIdx_t;

    typedef struct packed {
        robIdx_t              rob_idx;
        ftqIdx_t              ftq_idx;
        brobIdx_t             brob_idx;
        logic                 has_mispred;
        logic                 branch_taken;
        logic [VADDR_W-1:0]   branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic                 dueToBranch;
        logic                 branch_taken;
        logic [VADDR_W-1:0]   arch_pc;
    } squashInfo_t;

    // Held entry: the writeback payload minus the mispredict flag, which is implied.
    typedef struct packed {
        robIdx_t              rob_idx;
        ftqIdx_t              ftq_idx;
        brobIdx_t             brob_idx;
        logic                 branch_taken;
        logic [VADDR_W-1:0]   branch_npc;
    } pendEntry_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HELD   = 2'd1,
        S_SQUASH = 2'd2
    } trkState_t;

    function automatic logic older(input robIdx_t a, input robIdx_t b);
        if (a.flag == b.flag) return a.idx < b.idx;
        else                  return a.idx > b.idx;
    endfunction

    function automatic pendEntry_t to_pend(input branchwbInfo_t w);
        pendEntry_t p;
        p.rob_idx      = w.rob_idx;
        p.ftq_idx      = w.ftq_idx;
        p.brob_idx     = w.brob_idx;
        p.branch_taken = w.branch_taken;
        p.branch_npc   = w.branch_npc;
        return p;
    endfunction

endpackage

// File: rtl/branch_age_select.sv
// Oldest-of-N selection over ROB indices. Ties keep the lower input, so
// callers place their highest-priority source at index 0.
module branch_age_select
    import branch_squash_tracker_pkg::*;
#(
    parameter int N     = 3,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]          i_vld,
    input  robIdx_t [N-1:0]       i_rob_idx,
    output logic                  o_vld,
    output logic [SEL_W-1:0]      o_sel
);

    robIdx_t w_best;

    always_comb begin
        o_vld  = 1'b0;
        o_sel  = '0;
        w_best = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vld[i] && (!o_vld || older(i_rob_idx[i], w_best))) begin
                o_vld  = 1'b1;
                o_sel  = SEL_W'(i);
                w_best = i_rob_idx[i];
            end
        end
    end

endmodule

// File: rtl/branch_squash_tracker.sv
// Holds the oldest mispredicted branch from the BRU writeback ports and emits
// a one-cycle redirect when the ROB retires it.
//
// state    | meaning
// IDLE     | no mispredicted branch held
// HELD     | oldest mispredict held; ROB must not commit past it
// SQUASH   | redirect pulse cycle; writebacks from squashed path dropped
module branch_squash_tracker
    import branch_squash_tracker_pkg::*;
#(
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = 4,
    parameter int ROB_SIZE     = ROB_SIZE_P,
    parameter int CNT_W        = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WB_PORTS-1:0]           i_wb_vld,
    input  branchwbInfo_t [WB_PORTS-1:0]  i_wb_info,
    input  logic [COMMIT_WIDTH-1:0]       i_commit_vld,
    input  robIdx_t [COMMIT_WIDTH-1:0]    i_commit_rob_idx,
    input  logic                          i_flush,
    output logic                          o_pending_vld,
    output robIdx_t                       o_pending_rob_idx,
    output logic                          o_squash_vld,
    output squashInfo_t                   o_squash_info,
    output ftqIdx_t                       o_squash_ftq_idx,
    output brobIdx_t                      o_squash_brob_idx,
    output logic [CNT_W-1:0]              o_mispred_cnt
);

    localparam int N_SEL = WB_PORTS + 1;
    localparam int SEL_W = $clog2(N_SEL);
    localparam int IDX_W = $clog2(ROB_SIZE);

    trkState_t          r_state;
    trkState_t          w_state_nxt;
    pendEntry_t         r_pend;
    pendEntry_t         w_pend_nxt;
    squashInfo_t        r_sq_info;
    ftqIdx_t            r_sq_ftq;
    brobIdx_t           r_sq_brob;
    logic [CNT_W-1:0]   r_cnt;

    logic [N_SEL-1:0]   w_sel_vld;
    robIdx_t [N_SEL-1:0] w_sel_idx;
    logic               w_win_vld;
    logic [SEL_W-1:0]   w_win_sel;
    pendEntry_t         w_win;
    logic               w_match;
    logic               w_accept_wb;

    // Writebacks arriving during a flush or a redirect belong to squashed work.
    assign w_accept_wb = !i_flush && (r_state != S_SQUASH);

    always_comb begin
        w_sel_vld    = '0;
        w_sel_idx    = '0;
        w_sel_vld[0] = (r_state == S_HELD);
        w_sel_idx[0] = r_pend.rob_idx;
        for (int k = 0; k < WB_PORTS; k++) begin
            w_sel_vld[k+1] = i_wb_vld[k] && i_wb_info[k].has_mispred && w_accept_wb;
            w_sel_idx[k+1] = i_wb_info[k].rob_idx;
        end
    end

    branch_age_select #(
        .N      (N_SEL),
        .SEL_W  (SEL_W)
    ) u_age_select (
        .i_vld      (w_sel_vld),
        .i_rob_idx  (w_sel_idx),
        .o_vld      (w_win_vld),
        .o_sel      (w_win_sel)
    );

    always_comb begin
        w_win = r_pend;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (w_win_sel == SEL_W'(k + 1)) w_win = to_pend(i_wb_info[k]);
        end
    end

    always_comb begin
        w_match = 1'b0;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (i_commit_vld[c]
                && (i_commit_rob_idx[c].flag == r_pend.rob_idx.flag)
                && (i_commit_rob_idx[c].idx[IDX_W-1:0] == r_pend.rob_idx.idx[IDX_W-1:0]))
                w_match = 1'b1;
        end
        w_match = w_match && (r_state == S_HELD);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_HELD;
                    w_pend_nxt  = w_win;
                end
            end
            S_HELD: begin
                if (w_match) begin
                    w_state_nxt = S_SQUASH;
                    w_pend_nxt  = '0;
                end else if (i_flush) begin
                    w_state_nxt = S_IDLE;
                    w_pend_nxt  = '0;
                end else begin
                    w_pend_nxt  = w_win;
                end
            end
            S_SQUASH: begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pend_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Redirect payload is zero outside the pulse cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq_info <= '0;
            r_sq_ftq  <= '0;
            r_sq_brob <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_match) begin
                r_sq_info.dueToBranch  <= 1'b1;
                r_sq_info.branch_taken <= r_pend.branch_taken;
                r_sq_info.arch_pc      <= r_pend.branch_npc;
                r_sq_ftq               <= r_pend.ftq_idx;
                r_sq_brob              <= r_pend.brob_idx;
                if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            end else begin
                r_sq_info <= '0;
                r_sq_ftq  <= '0;
                r_sq_brob <= '0;
            end
        end
    end

    assign o_pending_vld     = (r_state == S_HELD);
    assign o_pending_rob_idx = r_pend.rob_idx;
    assign o_squash_vld      = (r_state == S_SQUASH);
    assign o_squash_info     = r_sq_info;
    assign o_squash_ftq_idx  = r_sq_ftq;
    assign o_squash_brob_idx = r_sq_brob;
    assign o_mispred_cnt     = r_cnt;

endmodule
